// File: rtl/ifetch_pkg.sv
// Shared constants and types for the dearv front end.
//   AW          : default imem byte-address width
//   RESET_PC    : default fetch address after reset (4-byte aligned)
//   IMEM_WORD_D : imem access size code for a doubleword
//   INST_W      : instruction width
//   alu_sel_e   : execute-stage ALU operation select codes
//   push_e      : number of instructions the fetch stage enqueues in a cycle
package ifetch_pkg;

  localparam int unsigned AW          = 10;
  localparam int unsigned RESET_PC    = 0;
  localparam logic [1:0]  IMEM_WORD_D = 2'd3;
  localparam int unsigned INST_W      = 32;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_SLL,
    ALU_SLT,
    ALU_SLTU,
    ALU_XOR,
    ALU_SRL,
    ALU_SRA,
    ALU_OR,
    ALU_AND
  } alu_sel_e;

  typedef enum logic [1:0] {
    PUSH_NONE,
    PUSH_ONE,
    PUSH_TWO
  } push_e;

endpackage

// File: rtl/ifetch_ifq.sv
// ifq: instruction queue between fetch and decode.
// Synchronous FIFO of {instruction, PC} entries, QDEPTH deep (power of two).
//   clk, rst_n          : clock, synchronous active-low reset
//   flush               : drop all entries (pointers and count cleared)
//   push2               : enqueue wr_inst0/wr_pc0 then wr_inst1/wr_pc1
//   push1               : enqueue wr_inst0/wr_pc0 only
//   pop                 : retire the head entry
//   count               : number of valid entries, 0..QDEPTH
//   head_inst, head_pc  : head entry, zero when the queue is empty
// The caller guarantees pushes fit and pops only happen when non-empty.
module ifq
  import ifetch_pkg::*;
#(
  parameter  int unsigned AW     = ifetch_pkg::AW,
  parameter  int unsigned QDEPTH = 4,
  localparam int unsigned CW     = $clog2(QDEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              push2,
  input  logic              push1,
  input  logic              pop,
  input  logic [INST_W-1:0] wr_inst0,
  input  logic [AW-1:0]     wr_pc0,
  input  logic [INST_W-1:0] wr_inst1,
  input  logic [AW-1:0]     wr_pc1,
  output logic [CW-1:0]     count,
  output logic [INST_W-1:0] head_inst,
  output logic [AW-1:0]     head_pc
);

  localparam int unsigned PW = $clog2(QDEPTH);

  logic [INST_W-1:0] r_inst [QDEPTH];
  logic [AW-1:0]     r_pc   [QDEPTH];
  logic [PW-1:0]     r_rd_ptr;
  logic [PW-1:0]     r_wr_ptr;
  logic [CW-1:0]     r_count;

  logic [PW-1:0]     w_wr_ptr1;
  logic [CW-1:0]     w_count_nxt;
  logic              w_empty;

  always_comb begin
    w_wr_ptr1   = r_wr_ptr + PW'(1);
    w_count_nxt = r_count;
    if (push2) begin
      w_count_nxt = w_count_nxt + CW'(2);
    end else if (push1) begin
      w_count_nxt = w_count_nxt + CW'(1);
    end
    if (pop) begin
      w_count_nxt = w_count_nxt - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_count <= w_count_nxt;
      if (pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      if (push2) begin
        r_wr_ptr <= r_wr_ptr + PW'(2);
      end else if (push1) begin
        r_wr_ptr <= w_wr_ptr1;
      end
    end
  end

  // Payload storage is not reset; the count alone defines what is valid.
  always_ff @(posedge clk) begin
    if (rst_n && !flush) begin
      if (push2 || push1) begin
        r_inst[r_wr_ptr] <= wr_inst0;
        r_pc[r_wr_ptr]   <= wr_pc0;
      end
      if (push2) begin
        r_inst[w_wr_ptr1] <= wr_inst1;
        r_pc[w_wr_ptr1]   <= wr_pc1;
      end
    end
  end

  assign w_empty   = (r_count == '0);
  assign count     = r_count;
  assign head_inst = w_empty ? '0 : r_inst[r_rd_ptr];
  assign head_pc   = w_empty ? '0 : r_pc[r_rd_ptr];

endmodule

// File: rtl/ifetch.sv
// ifetch: instruction fetch unit for the dearv RV64 core.
// Reads 64-bit doublewords from a combinational imem, splits them into two
// 32-bit instructions and queues them with their PCs for decode.
//   clk, rst_n   : clock, synchronous active-low reset
//   imem_addr    : doubleword-aligned fetch address
//   imem_word    : access size, constant doubleword
//   imem_data    : imem read data, same cycle as imem_addr
//   redirect     : flush the queue and restart fetch at redirect_pc
//   redirect_pc  : new fetch address (bits [1:0] ignored)
//   inst_valid   : queue head valid (never in a redirect cycle)
//   inst_ready   : decode accepts the head
//   inst, inst_pc: head instruction and PC, zero when the queue is empty
module ifetch
  import ifetch_pkg::*;
#(
  parameter int unsigned    AW       = ifetch_pkg::AW,
  parameter int unsigned    QDEPTH   = 4,
  parameter logic [AW-1:0]  RESET_PC = AW'(ifetch_pkg::RESET_PC)
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [AW-1:0]     imem_addr,
  output logic [1:0]        imem_word,
  input  logic [63:0]       imem_data,
  input  logic              redirect,
  input  logic [AW-1:0]     redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst,
  output logic [AW-1:0]     inst_pc
);

  localparam int unsigned CW = $clog2(QDEPTH + 1);

  logic [AW-1:0]     r_fetch_pc;

  logic [AW-1:0]     w_aligned;
  logic [AW-1:0]     w_pc_next;
  logic [CW-1:0]     w_count;
  logic              w_pop;
  push_e             w_push;
  logic [INST_W-1:0] w_wr_inst0;
  logic [AW-1:0]     w_wr_pc0;
  logic [INST_W-1:0] w_wr_inst1;
  logic [AW-1:0]     w_wr_pc1;

  assign w_aligned = {r_fetch_pc[AW-1:3], 3'b000};
  assign w_pc_next = w_aligned + AW'(8);
  assign imem_addr = w_aligned;
  assign imem_word = IMEM_WORD_D;

  // Free space is judged on the count before this cycle's pop, so a pop
  // only makes room for the following cycle.
  always_comb begin
    w_push = PUSH_NONE;
    if (!redirect) begin
      if (!r_fetch_pc[2] && (w_count <= CW'(QDEPTH - 2))) begin
        w_push = PUSH_TWO;
      end else if (r_fetch_pc[2] && (w_count != CW'(QDEPTH))) begin
        w_push = PUSH_ONE;
      end
    end
  end

  // A word-aligned fetch_pc with bit 2 set enqueues only the upper half,
  // so slot 0 takes whichever half sits at fetch_pc itself.
  always_comb begin
    w_wr_inst0 = r_fetch_pc[2] ? imem_data[63:32] : imem_data[31:0];
    w_wr_pc0   = r_fetch_pc;
    w_wr_inst1 = imem_data[63:32];
    w_wr_pc1   = r_fetch_pc + AW'(4);
  end

  assign inst_valid = (w_count != '0) && !redirect;
  assign w_pop      = inst_valid && inst_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fetch_pc <= RESET_PC;
    end else if (redirect) begin
      r_fetch_pc <= redirect_pc & {{(AW-2){1'b1}}, 2'b00};
    end else if (w_push != PUSH_NONE) begin
      r_fetch_pc <= w_pc_next;
    end
  end

  ifq #(
    .AW     (AW),
    .QDEPTH (QDEPTH)
  ) u_ifq (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect),
    .push2     (w_push == PUSH_TWO),
    .push1     (w_push == PUSH_ONE),
    .pop       (w_pop),
    .wr_inst0  (w_wr_inst0),
    .wr_pc0    (w_wr_pc0),
    .wr_inst1  (w_wr_inst1),
    .wr_pc1    (w_wr_pc1),
    .count     (w_count),
    .head_inst (inst),
    .head_pc   (inst_pc)
  );

endmodule

// File: tb/tb_ifetch.sv
// Self-checking bench for ifetch: directed scenarios followed by random
// ready/redirect/reset traffic, compared against a queue-based model.
module tb_ifetch;

  localparam int unsigned AW     = 10;
  localparam int unsigned QDEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] imem_addr;
  logic [1:0]    imem_word;
  logic [63:0]   imem_data;
  logic          redirect;
  logic [AW-1:0] redirect_pc;
  logic          inst_valid;
  logic          inst_ready;
  logic [31:0]   inst;
  logic [AW-1:0] inst_pc;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Reference state: fetch address and queued PCs (instruction = PC/4).
  int unsigned m_fpc;
  int unsigned m_q[$];
  bit          m_known = 1'b0;

  always #5 clk = ~clk;

  // imem word k holds {2k+1, 2k}.
  always_comb begin
    imem_data = {32'((imem_addr >> 3) * 2 + 1), 32'((imem_addr >> 3) * 2)};
  end

  ifetch #(
    .AW       (AW),
    .QDEPTH   (QDEPTH),
    .RESET_PC (10'h000)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_addr   (imem_addr),
    .imem_word   (imem_word),
    .imem_data   (imem_data),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst        (inst),
    .inst_pc     (inst_pc)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_edge(input logic rn, input logic red, input logic [AW-1:0] rpc,
                            input logic rdy);
    int unsigned free_slots;
    int unsigned al;
    bit          pushed;
    if (!rn) begin
      m_q.delete();
      m_fpc   = 0;
      m_known = 1'b1;
    end else if (red) begin
      m_q.delete();
      m_fpc = int'(rpc) & 32'h3FC;
    end else begin
      free_slots = QDEPTH - m_q.size();
      al         = m_fpc & ~32'h7;
      pushed     = 1'b0;
      if (m_q.size() != 0 && rdy) void'(m_q.pop_front());
      if ((m_fpc & 4) == 0 && free_slots >= 2) begin
        m_q.push_back(al);
        m_q.push_back(al + 4);
        pushed = 1'b1;
      end else if ((m_fpc & 4) != 0 && free_slots >= 1) begin
        m_q.push_back(m_fpc);
        pushed = 1'b1;
      end
      if (pushed) m_fpc = (al + 8) % (1 << AW);
    end
  endtask

  // One clock: drive inputs, check outputs mid-cycle, then advance model.
  task automatic cycle(input logic rn, input logic red, input logic [AW-1:0] rpc,
                       input logic rdy);
    bit          e_valid;
    int unsigned e_pc;
    rst_n       = rn;
    redirect    = red;
    redirect_pc = rpc;
    inst_ready  = rdy;
    @(negedge clk);
    if (m_known) begin
      e_valid = (m_q.size() != 0) && !red;
      e_pc    = (m_q.size() != 0) ? m_q[0] : 0;
      chk("inst_valid", 64'(inst_valid), 64'(e_valid));
      chk("inst_pc",    64'(inst_pc),    64'(e_pc));
      chk("inst",       64'(inst),       64'(e_pc >> 2));
      chk("imem_addr",  64'(imem_addr),  64'(m_fpc & ~32'h7));
      chk("imem_word",  64'(imem_word),  64'd3);
    end
    @(posedge clk);
    model_edge(rn, red, rpc, rdy);
    #1;
  endtask

  initial begin
    logic          r_rn;
    logic          r_red;
    logic [AW-1:0] r_rpc;
    logic          r_rdy;

    // Reset, then stream with ready held high.
    repeat (2) cycle(1'b0, 1'b0, '0, 1'b1);
    repeat (9) cycle(1'b1, 1'b0, '0, 1'b1);

    // Back-pressure until the queue saturates, then drain.
    repeat (6) cycle(1'b1, 1'b0, '0, 1'b0);
    repeat (8) cycle(1'b1, 1'b0, '0, 1'b1);

    // Redirect to 0x0C with a full queue.
    repeat (5) cycle(1'b1, 1'b0, '0, 1'b0);
    cycle(1'b1, 1'b1, 10'h00C, 1'b1);
    repeat (5) cycle(1'b1, 1'b0, '0, 1'b1);

    // Redirect to the top address; fetch wraps to 0.
    cycle(1'b1, 1'b1, 10'h3FC, 1'b1);
    repeat (5) cycle(1'b1, 1'b0, '0, 1'b1);

    // Queue three entries, then a one-cycle reset.
    cycle(1'b1, 1'b1, 10'h004, 1'b0);
    repeat (3) cycle(1'b1, 1'b0, '0, 1'b0);
    cycle(1'b0, 1'b0, '0, 1'b0);
    repeat (4) cycle(1'b1, 1'b0, '0, 1'b1);

    // Redirect while decode is ready with a non-empty queue.
    cycle(1'b1, 1'b0, '0, 1'b0);
    cycle(1'b1, 1'b1, 10'h020, 1'b1);
    repeat (4) cycle(1'b1, 1'b0, '0, 1'b1);

    // Random traffic, including misaligned redirect targets.
    for (int i = 0; i < 400; i++) begin
      r_rn  = ($urandom_range(0, 63) != 0);
      r_red = ($urandom_range(0, 11) == 0);
      r_rpc = AW'($urandom_range(0, (1 << AW) - 1));
      r_rdy = ($urandom_range(0, 3) != 0);
      cycle(r_rn, r_red, r_rpc, r_rdy);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ifetch.md
# ifetch

Instruction fetch unit for the dearv RV64 core. Drives the combinational instruction memory (`imem`) with doubleword-aligned byte addresses and splits each 64-bit word into two 32-bit instructions. Queues the instructions with their PCs in a small FIFO and hands them to decode over a valid/ready handshake. Accepts a redirect (branch/jump/trap target) from execute that flushes the queue and restarts fetch.

## Interface
Parameters:
- `AW`, 10: byte-address width of `imem`.
- `QDEPTH`, 4: instruction queue entries; power of two, at least 2.
- `RESET_PC`, 0: fetch address after reset; bits [1:0] must be 0.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `imem_addr`  out  AW  `{fetch_pc[AW-1:3], 3'b000}`.
- `imem_word`  out  2  constant 3 (doubleword access).
- `imem_data`  in  64  read data, valid in the same cycle as `imem_addr`.
- `redirect`  in  1  flush the queue and restart fetch at `redirect_pc`.
- `redirect_pc`  in  AW  new fetch address; bits [1:0] ignored.
- `inst_valid`  out  1  queue head is valid.
- `inst_ready`  in  1  decode accepts the head.
- `inst`  out  32  head instruction; 0 when the queue is empty.
- `inst_pc`  out  AW  head PC; 0 when the queue is empty.

## Operation
- State:
  - `fetch_pc`: AW bits, 4-byte aligned.
  - Queue: `QDEPTH` × {32-bit instruction, AW-bit PC}.
  - `count`: 0..`QDEPTH`.
- Word split: little-endian. `imem_data[31:0]` is the instruction at the aligned address; `imem_data[63:32]` is the instruction at aligned+4.
- Push rule (when `redirect`=0):
  - If `fetch_pc[2]`=0 and `QDEPTH-count` ≥ 2: push the low half with PC `fetch_pc`, then the high half with PC `fetch_pc+4`.
  - If `fetch_pc[2]`=1 and `QDEPTH-count` ≥ 1: push the high half only, with PC `fetch_pc`.
  - On any push: `fetch_pc <= aligned+8`, modulo 2^AW (wraps to 0 at the top).
  - Otherwise: no push and `fetch_pc` holds.
- Free space is computed from `count` before this cycle's pop. A pop in the same cycle frees space for the next cycle only. Simultaneous push and pop are legal: `count` changes by pushes minus pops.
- Pop: when `inst_valid && inst_ready`, the head retires in order.
- `inst_valid` = (`count`≠0) && !`redirect`. A handshake is impossible in a redirect cycle.
- Redirect, sampled high at an edge:
  - `count <= 0`.
  - `fetch_pc <= {redirect_pc[AW-1:2], 2'b00}`.
  - No push and no pop in that cycle.
  - Redirect dominates all other events.
  - Consecutive redirect cycles: the last one wins.
- Reset, sampled low at an edge: `count <= 0`, `fetch_pc <= RESET_PC`. The queue payload need not be cleared. Reset dominates redirect. Reset in mid-operation discards all queued instructions.
- No illegal states: `count` never exceeds `QDEPTH`; an empty queue never pops.

## Timing
- Output values while in reset and after the reset edge:
  - `inst_valid`=0, `inst`=0, `inst_pc`=0.
  - `imem_addr`=`RESET_PC` aligned down to 8.
  - `imem_word`=3.
- Latency:
  - First edge with `rst_n`=1 pushes; `inst_valid`=1 from the following cycle.
  - After redirect edge N, the push happens at edge N+1 and `inst_valid`=1 after edge N+1. Redirect-to-valid is 2 edges.
- Sustained throughput: one instruction per cycle with `inst_ready` held at 1.
- `inst` and `inst_pc` are driven from registered queue storage. There is no combinational path from `imem_data` to `inst`.
- `imem_addr` is a function of the registered `fetch_pc` only.

## Structure
- Shared constants go in the common constants header next to the ALU select codes:
  - `AW`, `RESET_PC`.
  - `IMEM_WORD_D` = 2'd3.
  - `INST_W` = 32.
- Sub-module `ifq`: a synchronous FIFO with `push2` / `push1` / `pop` / `flush` inputs, plus `count`, head data and head PC outputs. Width is 32+AW; depth is `QDEPTH`.
- `ifetch` holds `fetch_pc`, the push/redirect control and the imem port.

## Test plan
Bench: `imem` model where word k contains {32'h(2k+1), 32'h(2k)}; `RESET_PC`=0; `QDEPTH`=4.
- Reset, then hold `inst_ready`=1 for 8 cycles:
  - PCs 0,4,8,…,0x1C in consecutive cycles.
  - Instructions 0,1,2,…,7.
  - `inst_valid` low for exactly the first cycle after reset release.
- Hold `inst_ready`=0 for 6 cycles:
  - `count` saturates at 4 and `fetch_pc` stops at 0x10.
  - Raising `inst_ready` then drains 0,4,8,0xC, followed by 0x10 with no gap or duplicate.
- Redirect to 0x0C while the queue is full:
  - `inst_valid`=0 during the redirect cycle and the next cycle.
  - Then PC 0x0C (instruction 3), then PC 0x10 (instruction 4).
- Redirect to 0x3FC (top address, AW=10):
  - Delivers PC 0x3FC with instruction 0xFF.
  - Then wraps to PC 0x000 with instruction 0.
- `rst_n` low for one cycle with 3 entries queued:
  - Next cycle `inst_valid`=0, `inst`=0, `imem_addr`=0.
  - Fetch restarts at PC 0.
- `redirect` and `inst_valid && inst_ready` in the same cycle, target 0x20:
  - The head is not retired.
  - The next delivered PC is 0x20.
